mux_nx1_stream: RTL
===================

MUX_NX1_STREAM -- requirements
Module: mux_nx1_stream

Interface
REQ-001 Parameter bits, default 4: data width per channel.
REQ-002 Parameter chans, default 4: number of input channels, legal range 2..16.
REQ-003 Parameter DEFAULT_VAL, default 0: value driven on xout whenever xout_valid is 0.
REQ-004 Derived constant sel_w = max(1, clog2(chans)).
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 mode  input  1  0 = fixed select, 1 = round-robin.
REQ-008 sel  input  sel_w  requested channel for fixed mode.
REQ-009 sel_load  input  1  capture sel into the active-channel register.
REQ-010 xin  input  chans*bits  flattened channel data, channel i at bits [i*bits +: bits].
REQ-011 xin_valid  input  chans  per-channel valid.
REQ-012 xin_ready  output  chans  per-channel ready, at most one bit set.
REQ-013 xout  output  bits  registered selected data.
REQ-014 xout_valid  output  1  xout holds a beat.
REQ-015 xout_ready  input  1  downstream accepts the beat.
REQ-016 cur_sel  output  sel_w  active channel (fixed mode) or round-robin pointer (rr mode).
REQ-017 sel_err  output  1  sticky flag: out-of-range sel was loaded.

Function
REQ-018 The output slot is free when xout_valid=0 or xout_ready=1.
REQ-019 Fixed mode: grant = act_sel when xin_valid[act_sel]=1; otherwise no grant.
REQ-020 Round-robin mode: grant = first channel i with xin_valid[i]=1, searching rr_ptr, rr_ptr+1, ... wrapping modulo chans; no grant if none is valid.
REQ-021 xin_ready[g] = 1 only for the granted channel g and only while the slot is free; all other bits are 0.
REQ-022 A transfer occurs when xin_valid[g] and xin_ready[g] are both 1; xout takes xin channel g and xout_valid=1 on the next edge (latency 1 cycle).
REQ-023 Back-to-back transfers sustain 1 beat per cycle while xout_ready=1.
REQ-024 When xout_valid=1 and xout_ready=0: xout and xout_valid hold; all xin_ready bits are 0.
REQ-025 When xout_ready=1 with no new transfer: xout_valid becomes 0 and xout becomes DEFAULT_VAL.
REQ-026 On a round-robin transfer from channel g: rr_ptr = (g+1) mod chans, wrapping from chans-1 to 0.
REQ-027 sel_load with sel < chans: act_sel = sel on the next edge.
REQ-028 sel_load with sel >= chans: act_sel is unchanged, sel_err is set, and the stream continues on the old channel.
REQ-029 sel_err clears only on rst.
REQ-030 sel_load coincident with a transfer: the transfer uses the old act_sel; the new value applies from the next cycle.
REQ-031 A mode change takes effect on the next cycle; act_sel and rr_ptr both retain their values across mode changes.
REQ-032 cur_sel = act_sel when mode=0 and rr_ptr when mode=1.

Reset
REQ-033 rst asynchronously forces: xout_valid=0, xout=DEFAULT_VAL, act_sel=0, rr_ptr=0, sel_err=0, xin_ready=0.
REQ-034 A beat held in the output register when rst asserts is discarded.
REQ-035 Outputs stay at their reset values until the first rising clk edge after rst deasserts.

Structure
REQ-036 A shared package mux_pkg holds the MODE_FIXED=0 and MODE_RR=1 encodings and the clog2 sel-width function.
REQ-037 The round-robin grant logic is one sub-module, rr_arbiter_nx1 (inputs: request vector, pointer; outputs: grant index, grant valid).
REQ-038 The output register and handshake stay in the top level.

Verification
REQ-039 bits=4, chans=4, mode=0, sel_load sel=2, xin ch2=1010 valid, xout_ready=1 -> xin_ready=0100; next cycle xout=1010, xout_valid=1.
REQ-040 Same setup, xout_ready=0 for 3 cycles -> xout holds 1010, xin_ready=0000; on release the next beat follows with zero bubble.
REQ-041 mode=1, all four channels valid with values 1,2,3,4, xout_ready=1 -> xout sequence 1,2,3,4,1, and cur_sel wraps 3->0.
REQ-042 mode=1, only ch1 and ch3 valid, rr_ptr=2 -> ch3 is granted first, then ch1.
REQ-043 chans=3, sel_load sel=3 -> sel_err=1, act_sel is unchanged, the stream continues on the old channel, and sel_err persists until rst.
REQ-044 rst asserted mid-stream while xout_valid=1 -> same-cycle xout_valid=0, xout=DEFAULT_VAL, cur_sel=0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared encodings and sizing helper for the N:1 stream multiplexer.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Select width is clog2(n), but never narrower than one bit.
    function automatic int sel_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter_nx1.sv
// Round-robin pick: first requester at or after i_ptr, wrapping modulo N.
// Purely combinational; no state, no backpressure of its own.
module rr_arbiter_nx1 #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [W-1:0] o_gnt_idx,
    output logic         o_gnt_vld
);

    logic [2*N-1:0] w_dbl;
    logic [W:0]     w_sum;

    // Rotating a doubled copy puts the search start at bit 0; the lowest
    // set bit is then the offset from i_ptr.
    always_comb begin
        w_dbl     = {i_req, i_req} >> i_ptr;
        w_sum     = '0;
        o_gnt_vld = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_dbl[k]) begin
                w_sum     = {1'b0, i_ptr} + (W+1)'(k);
                o_gnt_vld = 1'b1;
            end
        end
        if (w_sum >= (W+1)'(N))
            w_sum = w_sum - (W+1)'(N);
        o_gnt_idx = w_sum[W-1:0];
    end

endmodule

// File: rtl/mux_nx1_stream.sv
// N:1 valid/ready stream mux, fixed-select or round-robin, 1-cycle registered output.
// Holds the output beat and drops every xin_ready while xout_ready is low.
module mux_nx1_stream
    import mux_pkg::*;
#(
    parameter int              bits        = 4,
    parameter int              chans       = 4,
    parameter logic [bits-1:0] DEFAULT_VAL = '0,
    localparam int             sel_w       = sel_width(chans)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [sel_w-1:0]      sel,
    input  logic                  sel_load,
    input  logic [chans*bits-1:0] xin,
    input  logic [chans-1:0]      xin_valid,
    output logic [chans-1:0]      xin_ready,
    output logic [bits-1:0]       xout,
    output logic                  xout_valid,
    input  logic                  xout_ready,
    output logic [sel_w-1:0]      cur_sel,
    output logic                  sel_err
);

    logic [sel_w-1:0] r_act_sel;
    logic [sel_w-1:0] r_rr_ptr;
    logic             r_sel_err;
    logic [bits-1:0]  r_xout;
    logic             r_xout_vld;

    logic [sel_w-1:0] w_rr_idx;
    logic             w_rr_vld;
    logic [sel_w-1:0] w_gnt_idx;
    logic             w_gnt_vld;
    logic             w_slot_free;
    logic             w_xfer;
    logic [bits-1:0]  w_gnt_dat;
    logic             w_sel_ok;

    rr_arbiter_nx1 #(
        .N (chans),
        .W (sel_w)
    ) u_rr (
        .i_req     (xin_valid),
        .i_ptr     (r_rr_ptr),
        .o_gnt_idx (w_rr_idx),
        .o_gnt_vld (w_rr_vld)
    );

    assign w_slot_free = !r_xout_vld || xout_ready;
    assign w_gnt_idx   = (mode == MODE_RR) ? w_rr_idx : r_act_sel;
    assign w_gnt_vld   = (mode == MODE_RR) ? w_rr_vld : xin_valid[r_act_sel];
    // Ready is forced low during reset even though the comb path would grant.
    assign w_xfer      = w_gnt_vld && w_slot_free && !rst;
    assign w_sel_ok    = ({1'b0, sel} < (sel_w+1)'(chans));

    always_comb begin
        w_gnt_dat = '0;
        xin_ready = '0;
        for (int i = 0; i < chans; i++) begin
            if (w_gnt_idx == sel_w'(i)) begin
                w_gnt_dat    = xin[i*bits +: bits];
                xin_ready[i] = w_xfer;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xout     <= DEFAULT_VAL;
            r_xout_vld <= 1'b0;
            r_act_sel  <= '0;
            r_rr_ptr   <= '0;
            r_sel_err  <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_xout     <= w_gnt_dat;
                r_xout_vld <= 1'b1;
            end else if (xout_ready) begin
                r_xout     <= DEFAULT_VAL;
                r_xout_vld <= 1'b0;
            end

            if (w_xfer && mode == MODE_RR)
                r_rr_ptr <= (w_gnt_idx == sel_w'(chans - 1)) ? '0 : w_gnt_idx + sel_w'(1);

            if (sel_load) begin
                if (w_sel_ok)
                    r_act_sel <= sel;
                else
                    r_sel_err <= 1'b1;
            end
        end
    end

    assign xout       = r_xout;
    assign xout_valid = r_xout_vld;
    assign sel_err    = r_sel_err;
    assign cur_sel    = (mode == MODE_RR) ? r_rr_ptr : r_act_sel;

endmodule
